im_loader: RTL and testbench
============================

// Module: im_loader
// PURPOSE
//  Writer side of the 1024x16 instruction memory: receives a program as a byte
//  stream (valid/ready), packs byte pairs into 16-bit instructions (high byte first)
//  and writes them to consecutive IM addresses from 0. Holds the CPU while loading.
//  Sits between the host/test link and the IM write port; the CPU fetch port is unchanged.
// PARAMETERS
//  ADDR_W  10    IM address width (depth = 2**ADDR_W = 1024 words)
//  WORD_W  16    instruction width; must be 16 (two bytes per word)
// PORTS
//  clk         in   1       rising-edge clock
//  rst_n       in   1       synchronous active-low reset
//  start       in   1       1-cycle request to begin a load; sampled only in IDLE
//  len         in   11      number of words to load, legal 1..1024
//  byte_in     in   8       stream data
//  byte_valid  in   1       stream data valid
//  byte_ready  out  1       loader accepts byte_in this cycle (byte_valid & byte_ready)
//  im_we       out  1       IM write enable, one cycle per word
//  im_addr     out  ADDR_W  IM write address
//  im_wdata    out  WORD_W  IM write data {hi_byte, lo_byte}
//  cpu_hold    out  1       CPU held (no fetch/PC advance) while high
//  busy        out  1       state != IDLE
//  done        out  1       1-cycle pulse: last word written
//  err_len     out  1       1-cycle pulse: start with illegal len, load not begun
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): state=IDLE; all outputs 0; addr/count/hi regs cleared.
//   Reset mid-load aborts at once; words already written stay in IM; no done pulse.
//  States: IDLE, HI, LO, WR, DONE.
//  IDLE: byte_ready=0. start & len in 1..1024 -> HI, addr<=0, remaining<=len,
//   cpu_hold<=1. start & (len==0 | len>1024) -> err_len=1 next cycle, stay IDLE.
//  HI:  byte_ready=1. On handshake hi<=byte_in -> LO. No handshake: stay.
//  LO:  byte_ready=1. On handshake lo<=byte_in -> WR. No handshake: stay.
//  WR:  byte_ready=0; im_we=1, im_addr=addr, im_wdata={hi,lo} (registered, valid
//   in this cycle only). remaining==1 -> DONE; else addr<=addr+1,
//   remaining<=remaining-1 -> HI.
//  DONE: done=1, cpu_hold=1 this cycle; -> IDLE (cpu_hold=0 from next cycle).
//  im_addr/im_wdata hold last written values outside WR; im_we=0 outside WR.
//  Throughput: 3 cycles/word minimum; first byte accepted the cycle after start.
//  start while busy: ignored (no effect, no err_len). byte_valid in IDLE/WR/DONE:
//   not accepted (byte_ready=0); source must hold the byte.
//  len=1024: addr reaches 1023 on final WR; addr never wraps; remaining is 11 bits.
//  cpu_hold = 1 in HI, LO, WR, DONE; 0 in IDLE.
// TESTING
//  1. start,len=3; bytes 12 34 56 78 9A BC back-to-back -> writes IM[0]=1234,
//     IM[1]=5678, IM[2]=9ABC, im_we exactly 3 cycles, done pulse after 3rd WR.
//  2. start,len=0 and len=1025 -> err_len 1-cycle pulse each, busy/cpu_hold stay 0,
//     no im_we.
//  3. len=2 with byte_valid gaps (valid low 0..5 random cycles) -> same IM contents,
//     no byte dropped or duplicated; byte_ready low in WR.
//  4. start pulsed again in HI/LO/WR of len=2 load -> ignored; exactly 2 writes, 1 done.
//  5. rst_n low in LO of word 1 (len=4) -> next cycle all outputs 0, IDLE; IM[0] kept;
//     new start,len=1, bytes AA 55 -> IM[0]=AA55.
//  6. len=1024 pseudo-random stream -> 1024 writes, addresses 0..1023 in order,
//     final address 1023, contents match scoreboard.

Source files
------------

// File: rtl/im_loader.sv
// im_loader: writer side of the instruction memory. Packs a valid/ready byte
// stream into 16-bit words (high byte first), writes them to consecutive IM
// addresses starting at 0, and holds the CPU for the duration of the load.
module im_loader #(
    parameter int ADDR_W = 10,
    parameter int WORD_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [WORD_W-1:0] im_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err_len
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HI,
        S_LO,
        S_WR,
        S_DONE
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W:0]     remaining_q;
    logic [7:0]          hi_q;
    logic                byte_ready_q;
    logic                im_we_q;
    logic [ADDR_W-1:0]   im_addr_q;
    logic [WORD_W-1:0]   im_wdata_q;
    logic                cpu_hold_q;
    logic                busy_q;
    logic                done_q;
    logic                err_len_q;

    logic                accept_d;
    logic                len_ok_d;

    // Handshake qualifier and length legality (1..DEPTH words).
    always_comb begin
        accept_d = byte_valid && byte_ready_q;
        len_ok_d = (len != '0) && (32'(len) <= DEPTH);
    end

    // Load sequencer; every output is registered and updated on state entry so
    // it is valid for exactly the cycles the state is occupied. The low byte is
    // captured straight into im_wdata_q on LO->WR, so no separate lo register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            remaining_q  <= '0;
            hi_q         <= '0;
            byte_ready_q <= 1'b0;
            im_we_q      <= 1'b0;
            im_addr_q    <= '0;
            im_wdata_q   <= '0;
            cpu_hold_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_len_q    <= 1'b0;
        end else begin
            im_we_q   <= 1'b0;
            done_q    <= 1'b0;
            err_len_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (len_ok_d) begin
                            state_q      <= S_HI;
                            addr_q       <= '0;
                            remaining_q  <= len;
                            cpu_hold_q   <= 1'b1;
                            busy_q       <= 1'b1;
                            byte_ready_q <= 1'b1;
                        end else begin
                            err_len_q <= 1'b1;
                        end
                    end
                end
                S_HI: begin
                    if (accept_d) begin
                        hi_q    <= byte_in;
                        state_q <= S_LO;
                    end
                end
                S_LO: begin
                    if (accept_d) begin
                        state_q      <= S_WR;
                        byte_ready_q <= 1'b0;
                        im_we_q      <= 1'b1;
                        im_addr_q    <= addr_q;
                        im_wdata_q   <= {hi_q, byte_in};
                    end
                end
                S_WR: begin
                    if (remaining_q == (ADDR_W + 1)'(1)) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        addr_q       <= addr_q + 1'b1;
                        remaining_q  <= remaining_q - 1'b1;
                        state_q      <= S_HI;
                        byte_ready_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q    <= S_IDLE;
                    cpu_hold_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
                default: begin
                    state_q      <= S_IDLE;
                    cpu_hold_q   <= 1'b0;
                    busy_q       <= 1'b0;
                    byte_ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Output ports driven directly from their registers.
    always_comb begin
        byte_ready = byte_ready_q;
        im_we      = im_we_q;
        im_addr    = im_addr_q;
        im_wdata   = im_wdata_q;
        cpu_hold   = cpu_hold_q;
        busy       = busy_q;
        done       = done_q;
        err_len    = err_len_q;
    end

endmodule

// File: tb/tb_im_loader.sv
// tb_im_loader: randomized byte-stream loads checked against a word-list
// reference built from the byte stream, plus a shadow IM filled from im_we.
module tb_im_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [10:0] len;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        im_we;
    logic [9:0]  im_addr;
    logic [15:0] im_wdata;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        err_len;

    always #5 clk = ~clk;

    im_loader #(.ADDR_W(10), .WORD_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .len        (len),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .im_we      (im_we),
        .im_addr    (im_addr),
        .im_wdata   (im_wdata),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .err_len    (err_len)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Shadow IM and write log observed on the write port.
    logic [15:0] im_mem [1024];
    int          wr_addr_q[$];
    int          wr_data_q[$];
    int          done_cnt = 0;
    int          err_cnt  = 0;
    int          cyc      = 0;
    int          last_we_cyc = 0;
    int          done_cyc    = 0;

    always @(negedge clk) begin
        cyc++;
        if (im_we) begin
            wr_addr_q.push_back(int'(im_addr));
            wr_data_q.push_back(int'(im_wdata));
            im_mem[im_addr] = im_wdata;
            last_we_cyc = cyc;
            check("rdy_low_in_wr", {31'b0, byte_ready}, 32'd0);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (err_len) err_cnt++;
        if (rst_n === 1'b1) check("hold_vs_busy", {31'b0, cpu_hold}, {31'b0, busy});
    end

    task automatic check_all_zero(input string tag);
        logic [31:0] agg;
        agg = {byte_ready, im_we, cpu_hold, busy, done, err_len, 26'b0};
        check({tag, "_ctl"}, agg, 32'd0);
        check({tag, "_addr"}, {22'b0, im_addr}, 32'd0);
        check({tag, "_wdata"}, {16'b0, im_wdata}, 32'd0);
    endtask

    // Present one byte after a gap and hold it until accepted. Optionally
    // pokes start (with an illegal len) while the load is running.
    task automatic send_byte(input logic [7:0] b, input int gap, input bit poke, output bit ok);
        int t;
        ok = 1'b1;
        byte_valid = 1'b0;
        repeat (gap) @(negedge clk);
        byte_in    = b;
        byte_valid = 1'b1;
        if (poke) begin
            start = 1'b1;
            len   = 11'd0;
        end
        t = 0;
        while (!byte_ready && t < 50) begin
            @(negedge clk);
            start = 1'b0;
            t++;
        end
        if (!byte_ready) begin
            check("handshake_timeout", 32'd1, 32'd0);
            ok = 1'b0;
        end
        @(negedge clk);
        start      = 1'b0;
        byte_valid = 1'b0;
    endtask

    // One complete load with reference comparison.
    task automatic run_load(input int n, input int maxgap, input bit poke, input logic [7:0] bytes[$]);
        int  done0, err0, t;
        bit  ok;
        wr_addr_q.delete();
        wr_data_q.delete();
        done0 = done_cnt;
        err0  = err_cnt;
        start = 1'b1;
        len   = 11'(n);
        @(negedge clk);
        start = 1'b0;
        check("rdy_after_start", {31'b0, byte_ready}, 32'd1);
        check("busy_after_start", {31'b0, busy}, 32'd1);
        for (int i = 0; i < 2 * n; i++) begin
            send_byte(bytes[i], (maxgap == 0) ? 0 : int'($urandom_range(maxgap, 0)), poke, ok);
            if (!ok) return;
        end
        t = 0;
        while (!done && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("done_seen", {31'b0, done}, 32'd1);
        check("hold_in_done", {31'b0, cpu_hold}, 32'd1);
        @(negedge clk);
        check("idle_after_done", {29'b0, cpu_hold, busy, done}, 32'd0);
        @(negedge clk);
        check("n_writes", wr_addr_q.size(), n);
        for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
            check("wr_addr", wr_addr_q[i], i);
            check("wr_data", wr_data_q[i], {16'b0, bytes[2*i], bytes[2*i+1]});
        end
        check("done_pulses", done_cnt - done0, 1);
        check("done_after_last_we", done_cyc, last_we_cyc + 1);
        check("addr_held", {22'b0, im_addr}, n - 1);
        check("no_err_len", err_cnt - err0, 0);
    endtask

    initial begin
        logic [7:0] bq[$];
        bit         ok;

        rst_n      = 1'b0;
        start      = 1'b0;
        len        = '0;
        byte_in    = '0;
        byte_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Fixed three-word load, back-to-back bytes.
        bq = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
        run_load(3, 0, 1'b0, bq);
        check("t1_im0", {16'b0, im_mem[0]}, 32'h1234);
        check("t1_im2", {16'b0, im_mem[2]}, 32'h9ABC);

        // Illegal lengths.
        wr_addr_q.delete();
        for (int k = 0; k < 2; k++) begin
            start = 1'b1;
            len   = (k == 0) ? 11'd0 : 11'd1025;
            @(negedge clk);
            start = 1'b0;
            check("err_len_pulse", {31'b0, err_len}, 32'd1);
            check("err_no_busy", {30'b0, busy, cpu_hold}, 32'd0);
            @(negedge clk);
            check("err_len_clear", {31'b0, err_len}, 32'd0);
            check("err_still_idle", {30'b0, busy, byte_ready}, 32'd0);
        end
        check("err_no_writes", wr_addr_q.size(), 0);

        // Random bytes with random valid gaps.
        for (int r = 0; r < 4; r++) begin
            bq.delete();
            for (int i = 0; i < 4; i++) bq.push_back(8'($urandom));
            run_load(2, 5, 1'b0, bq);
        end

        // start poked (illegal len) through HI/LO/WR of a running load.
        bq.delete();
        for (int i = 0; i < 4; i++) bq.push_back(8'($urandom));
        run_load(2, 2, 1'b1, bq);

        // Reset during LO of the second word.
        wr_addr_q.delete();
        start = 1'b1;
        len   = 11'd4;
        @(negedge clk);
        start = 1'b0;
        send_byte(8'h11, 0, 1'b0, ok);
        send_byte(8'h22, 0, 1'b0, ok);
        send_byte(8'h33, 0, 1'b0, ok);
        rst_n = 1'b0;
        @(negedge clk);
        check_all_zero("mid_reset");
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_im0_kept", {16'b0, im_mem[0]}, 32'h1122);
        check("rst_one_write", wr_addr_q.size(), 1);
        bq = '{8'hAA, 8'h55};
        run_load(1, 0, 1'b0, bq);
        check("rst_reload_im0", {16'b0, im_mem[0]}, 32'hAA55);

        // Full-depth load.
        bq.delete();
        for (int i = 0; i < 2048; i++) bq.push_back(8'($urandom));
        run_load(1024, 0, 1'b0, bq);
        check("full_last_addr", {22'b0, im_addr}, 32'd1023);
        check("full_im1023", {16'b0, im_mem[1023]}, {16'b0, bq[2046], bq[2047]});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=1 exp=0");
        $fatal(1, "timeout");
    end

endmodule
